awb_gain_stage: RTL and testbench

- Auto-white-balance gain stage directly upstream of the gamma corrector.
- Takes three 12-bit colour planes from demosaic and multiplies each by its own unsigned Q4.8 gain, with rounding and saturation.
- Emits a 3-cycle-latency 12-bit stream whose valid/data pins wire straight into gammaCorrector (inpvalid/din0..2).
- Also accumulates per-frame channel sums so firmware can compute the next frame's gains; gain changes are double-buffered and take effect only on frame boundaries.

---
 rtl/awb_gain_stage.sv | 181 ++++++++++++++++++
 tb/tb_awb_gain_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/awb_gain_stage.sv
// awb_gain_stage: per-plane Q(GW-8).8 white-balance gain with rounding and
// saturation, 3-cycle fixed latency, plus per-frame raw channel statistics.
// Gains are double-buffered (shadow -> active on frame start).
module awb_gain_stage #(
  parameter int DW    = 12,
  parameter int GW    = 12,
  parameter int ACC_W = 32,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fs,
  input  logic             inpvalid,
  input  logic [DW-1:0]    din0,
  input  logic [DW-1:0]    din1,
  input  logic [DW-1:0]    din2,
  input  logic [GW-1:0]    gain0,
  input  logic [GW-1:0]    gain1,
  input  logic [GW-1:0]    gain2,
  input  logic             gain_wr,
  output logic             outvalid,
  output logic [DW-1:0]    dout0,
  output logic [DW-1:0]    dout1,
  output logic [DW-1:0]    dout2,
  output logic [ACC_W-1:0] sum0,
  output logic [ACC_W-1:0] sum1,
  output logic [ACC_W-1:0] sum2,
  output logic [CNT_W-1:0] pixcnt,
  output logic             stats_valid
);

  localparam int PW = DW + GW;
  localparam logic [GW-1:0] UNITY = GW'(9'h100);

  // Round-half-up by 8 fractional bits, then clamp to the plane maximum.
  function automatic logic [DW-1:0] round_sat(input logic [PW-1:0] p);
    logic [PW:0] r;
    r = ({1'b0, p} + (PW+1)'(9'd128)) >> 8;
    if (r > {{(PW+1-DW){1'b0}}, {DW{1'b1}}}) begin
      round_sat = {DW{1'b1}};
    end else begin
      round_sat = r[DW-1:0];
    end
  endfunction

  // Saturating accumulate of a raw pixel into a statistics accumulator.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a,
                                               input logic [DW-1:0] d);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W+1-DW){1'b0}}, d};
    if (s[ACC_W]) begin
      sat_acc = {ACC_W{1'b1}};
    end else begin
      sat_acc = s[ACC_W-1:0];
    end
  endfunction

  logic [2:0][DW-1:0]    din_s;
  logic [2:0][GW-1:0]    gin_s;
  logic [2:0][GW-1:0]    shadow_r;
  logic [2:0][GW-1:0]    active_r;
  logic [2:0][GW-1:0]    gsel_s;
  logic                  s1_vld_r;
  logic [2:0][DW-1:0]    s1_d_r;
  logic [2:0][GW-1:0]    s1_g_r;
  logic                  s2_vld_r;
  logic [2:0][PW-1:0]    s2_p_r;
  logic [2:0][ACC_W-1:0] acc_r;
  logic [CNT_W-1:0]      cnt_r;

  assign din_s = {din2, din1, din0};
  assign gin_s = {gain2, gain1, gain0};

  // Gain a pixel will use: on frame start it is the value being promoted to
  // active (including a same-cycle write), otherwise the current active gain.
  always_comb begin
    gsel_s = active_r;
    if (fs) begin
      if (gain_wr) begin
        gsel_s = gin_s;
      end else begin
        gsel_s = shadow_r;
      end
    end else begin
      gsel_s = active_r;
    end
  end

  // Shadow/active gain double-buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_r <= {3{UNITY}};
      active_r <= {3{UNITY}};
    end else begin
      if (gain_wr) begin
        shadow_r <= gin_s;
      end
      if (fs) begin
        active_r <= gsel_s;
      end
    end
  end

  // Stages 1 and 2: capture pixel with its gain, then form the full product.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_r <= 1'b0;
      s1_d_r   <= '0;
      s1_g_r   <= '0;
      s2_vld_r <= 1'b0;
      s2_p_r   <= '0;
    end else begin
      s1_vld_r <= inpvalid;
      s2_vld_r <= s1_vld_r;
      if (inpvalid) begin
        s1_d_r <= din_s;
        s1_g_r <= gsel_s;
      end
      if (s1_vld_r) begin
        for (int k = 0; k < 3; k++) begin
          s2_p_r[k] <= PW'(s1_d_r[k]) * PW'(s1_g_r[k]);
        end
      end
    end
  end

  // Stage 3: rounded, saturated outputs; data holds when no pixel emerges.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outvalid <= 1'b0;
      dout0    <= '0;
      dout1    <= '0;
      dout2    <= '0;
    end else begin
      outvalid <= s2_vld_r;
      if (s2_vld_r) begin
        dout0 <= round_sat(s2_p_r[0]);
        dout1 <= round_sat(s2_p_r[1]);
        dout2 <= round_sat(s2_p_r[2]);
      end
    end
  end

  // Per-frame raw statistics; a pixel arriving with fs opens the new frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      sum0        <= '0;
      sum1        <= '0;
      sum2        <= '0;
      pixcnt      <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= fs;
      if (fs) begin
        sum0   <= acc_r[0];
        sum1   <= acc_r[1];
        sum2   <= acc_r[2];
        pixcnt <= cnt_r;
        if (inpvalid) begin
          for (int k = 0; k < 3; k++) begin
            acc_r[k] <= ACC_W'(din_s[k]);
          end
          cnt_r <= CNT_W'(1'b1);
        end else begin
          acc_r <= '0;
          cnt_r <= '0;
        end
      end else if (inpvalid) begin
        for (int k = 0; k < 3; k++) begin
          acc_r[k] <= sat_acc(acc_r[k], din_s[k]);
        end
        if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_r <= cnt_r + CNT_W'(1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_awb_gain_stage.sv
// Scoreboard bench for awb_gain_stage: a default build plus a narrow build
// (12-bit accumulators, 2-bit counter) driven by the same stimulus.
module tb_awb_gain_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fs = 1'b0;
  logic        inpvalid = 1'b0;
  logic        gain_wr = 1'b0;
  logic [11:0] din0 = 12'h0, din1 = 12'h0, din2 = 12'h0;
  logic [11:0] gain0 = 12'h0, gain1 = 12'h0, gain2 = 12'h0;

  logic        outvalid, stats_valid;
  logic [11:0] dout0, dout1, dout2;
  logic [31:0] sum0, sum1, sum2;
  logic [23:0] pixcnt;

  logic        outvalid_n, stats_valid_n;
  logic [11:0] dout0_n, dout1_n, dout2_n;
  logic [11:0] sum0_n, sum1_n, sum2_n;
  logic [1:0]  pixcnt_n;

  awb_gain_stage dut (
    .clk(clk), .rstn(rstn), .fs(fs), .inpvalid(inpvalid),
    .din0(din0), .din1(din1), .din2(din2),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain_wr(gain_wr),
    .outvalid(outvalid), .dout0(dout0), .dout1(dout1), .dout2(dout2),
    .sum0(sum0), .sum1(sum1), .sum2(sum2), .pixcnt(pixcnt),
    .stats_valid(stats_valid)
  );

  awb_gain_stage #(.ACC_W(12), .CNT_W(2)) dut_n (
    .clk(clk), .rstn(rstn), .fs(fs), .inpvalid(inpvalid),
    .din0(din0), .din1(din1), .din2(din2),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain_wr(gain_wr),
    .outvalid(outvalid_n), .dout0(dout0_n), .dout1(dout1_n), .dout2(dout2_n),
    .sum0(sum0_n), .sum1(sum1_n), .sum2(sum2_n), .pixcnt(pixcnt_n),
    .stats_valid(stats_valid_n)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [11:0] d0, d1, d2; } px_t;
  typedef struct packed { logic [31:0] s0, s1, s2; logic [23:0] c; } st_t;

  px_t pq[$];
  st_t sq[$];
  st_t sqn[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus, then return inputs to idle.
  task automatic step(input logic f, input logic w, input logic v,
                      input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2,
                      input logic [11:0] g0, input logic [11:0] g1, input logic [11:0] g2);
    fs = f; gain_wr = w; inpvalid = v;
    din0 = d0; din1 = d1; din2 = d2;
    gain0 = g0; gain1 = g1; gain2 = g2;
    @(posedge clk); #1;
    fs = 1'b0; gain_wr = 1'b0; inpvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pix(input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2,
                     input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2);
    pq.push_back({e0, e1, e2});
    step(1'b0, 1'b0, 1'b1, d0, d1, d2, 12'h0, 12'h0, 12'h0);
  endtask

  task automatic exp_st(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [23:0] ac,
                        input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                        input logic [23:0] bc);
    sq.push_back({a0, a1, a2, ac});
    sqn.push_back({b0, b1, b2, bc});
  endtask

  // Monitor: pop and compare whenever either build presents output or stats.
  always @(negedge clk) begin
    px_t e;
    st_t s;
    if (outvalid || outvalid_n) begin
      checks++;
      if (pq.size() == 0) begin
        failures++;
        $display("FAIL px_spurious outvalid=%0b/%0b with no expected pixel", outvalid, outvalid_n);
      end else begin
        e = pq.pop_front();
        if (!outvalid || !outvalid_n || dout0 !== e.d0 || dout1 !== e.d1 || dout2 !== e.d2 ||
            dout0_n !== e.d0 || dout1_n !== e.d1 || dout2_n !== e.d2) begin
          failures++;
          $display("FAIL px actual=%0b %h %h %h / %0b %h %h %h expected=%h %h %h",
                   outvalid, dout0, dout1, dout2, outvalid_n, dout0_n, dout1_n, dout2_n,
                   e.d0, e.d1, e.d2);
        end
      end
    end
    if (stats_valid) begin
      checks++;
      if (sq.size() == 0) begin
        failures++;
        $display("FAIL st_spurious stats_valid=1 with no expected frame");
      end else begin
        s = sq.pop_front();
        if (sum0 !== s.s0 || sum1 !== s.s1 || sum2 !== s.s2 || pixcnt !== s.c) begin
          failures++;
          $display("FAIL st actual=%h %h %h cnt=%0d expected=%h %h %h cnt=%0d",
                   sum0, sum1, sum2, pixcnt, s.s0, s.s1, s.s2, s.c);
        end
      end
    end
    if (stats_valid_n) begin
      checks++;
      if (sqn.size() == 0) begin
        failures++;
        $display("FAIL stn_spurious stats_valid=1 with no expected frame");
      end else begin
        s = sqn.pop_front();
        if ({20'd0, sum0_n} !== s.s0 || {20'd0, sum1_n} !== s.s1 ||
            {20'd0, sum2_n} !== s.s2 || {22'd0, pixcnt_n} !== s.c) begin
          failures++;
          $display("FAIL stn actual=%h %h %h cnt=%0d expected=%h %h %h cnt=%0d",
                   sum0_n, sum1_n, sum2_n, pixcnt_n, s.s0, s.s1, s.s2, s.c);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outvalid", {31'd0, outvalid}, 32'd0);
    chk("rst_dout0", {20'd0, dout0}, 32'd0);
    chk("rst_dout1", {20'd0, dout1}, 32'd0);
    chk("rst_dout2", {20'd0, dout2}, 32'd0);
    chk("rst_sum0", sum0, 32'd0);
    chk("rst_pixcnt", {8'd0, pixcnt}, 32'd0);
    chk("rst_stats_valid", {31'd0, stats_valid}, 32'd0);
    rstn = 1'b1;
    idle(2);

    // Unity gain after reset
    pix(12'h123, 12'h800, 12'hFFF, 12'h123, 12'h800, 12'hFFF);
    idle(4);

    // Gain math and saturation
    step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0, 12'h180, 12'h080, 12'h200);
    exp_st(32'h123, 32'h800, 32'hFFF, 24'd1, 32'h123, 32'h800, 32'hFFF, 24'd1);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    pix(12'h0AB, 12'h0AB, 12'h0AB, 12'h101, 12'h056, 12'h156);
    pix(12'h0AB, 12'h0AB, 12'h900, 12'h101, 12'h056, 12'hFFF);

    // Mid-frame write keeps the old gain until the next frame start
    step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0, 12'h200, 12'h080, 12'h200);
    pix(12'h100, 12'h100, 12'h100, 12'h180, 12'h080, 12'h200);
    exp_st(32'h256, 32'h256, 32'hAAB, 24'd3, 32'h256, 32'h256, 32'hAAB, 24'd3);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    pix(12'h100, 12'h100, 12'h100, 12'h200, 12'h080, 12'h200);

    // Write-through: gain_wr, fs and a pixel in one cycle
    exp_st(32'h100, 32'h100, 32'h100, 24'd1, 32'h100, 32'h100, 32'h100, 24'd1);
    pq.push_back({12'h010, 12'h030, 12'h004});
    step(1'b1, 1'b1, 1'b1, 12'h010, 12'h010, 12'h010, 12'h100, 12'h300, 12'h040);
    idle(4);

    // Statistics: fs-coincident pixel forms its own frame, then a 4-pixel frame
    exp_st(32'h010, 32'h010, 32'h010, 24'd1, 32'h010, 32'h010, 32'h010, 24'd1);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    repeat (4) pix(12'h100, 12'h100, 12'h100, 12'h100, 12'h300, 12'h040);
    exp_st(32'h400, 32'h400, 32'h400, 24'd4, 32'h400, 32'h400, 32'h400, 24'd3);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    // Empty frame (back-to-back fs)
    exp_st(32'h0, 32'h0, 32'h0, 24'd0, 32'h0, 32'h0, 32'h0, 24'd0);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);

    // Accumulator saturation on the narrow build
    repeat (5) pix(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h400);
    exp_st(32'h4FFB, 32'h4FFB, 32'h4FFB, 24'd5, 32'hFFF, 32'hFFF, 32'hFFF, 24'd3);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    idle(4);

    // Reset mid-operation with two pixels in flight
    exp_st(32'h0, 32'h0, 32'h0, 24'd0, 32'h0, 32'h0, 32'h0, 24'd0);
    step(1'b1, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0, 12'h200, 12'h200, 12'h200);
    pix(12'h100, 12'h100, 12'h100, 12'h200, 12'h200, 12'h200);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 12'h100, 12'h100, 12'h100, 12'h0, 12'h0, 12'h0);
    step(1'b0, 1'b0, 1'b1, 12'h100, 12'h100, 12'h100, 12'h0, 12'h0, 12'h0);
    rstn = 1'b0;
    idle(3);
    chk("midrst_outvalid", {31'd0, outvalid}, 32'd0);
    chk("midrst_pixcnt", {8'd0, pixcnt}, 32'd0);
    rstn = 1'b1;
    idle(4);
    chk("postrst_outvalid", {31'd0, outvalid}, 32'd0);
    exp_st(32'h0, 32'h0, 32'h0, 24'd0, 32'h0, 32'h0, 32'h0, 24'd0);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    pix(12'h100, 12'h0AB, 12'hFFF, 12'h100, 12'h0AB, 12'hFFF);
    idle(6);

    chk("pix_queue_drained", pq.size(), 32'd0);
    chk("stats_queue_drained", sq.size(), 32'd0);
    chk("stats_n_queue_drained", sqn.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
